// File: rtl/sobel_pkg.sv
// Shared Sobel definitions: pixel width/max value and the post-FIFO entry type.
// Used by sobel_top, sobel_edge_post and the benches.
// No logic; types and constants only.
package sobel_pkg;

    localparam int             PIX_W   = 8;
    localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

    // One post-processed pixel with its raster markers, as stored in the FIFO.
    typedef struct packed {
        logic             sof;
        logic             eol;
        logic             eof;
        logic [PIX_W-1:0] pix;
    } post_entry_t;

    localparam int POST_ENTRY_W = $bits(post_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous show-ahead FIFO with an occupancy counter.
// Latency: a write is visible at rd_data the cycle after it is accepted.
// Backpressure: a write is accepted when not full or when a read pops in the same
//   cycle; otherwise it is ignored (caller detects the drop). Ports: clk, rst,
//   wr_en/wr_data, rd_en/rd_data (head), count (occupancy 0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             rd_fire;
    logic             wr_fire;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign rd_fire = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read out unless count says it was written.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sobel_edge_post.sv
// Sobel post stage: raster tracking, border blanking, per-frame threshold, marker tagging.
// Latency: 2 cycles minimum (stage register, then FIFO write); 1 pixel/cycle sustained.
// Backpressure: pix_ready stalls only the output FIFO; upstream never stalls, a full FIFO
//   drops the pixel and sets sticky overflow. Ports: edge_in/edge_valid in, threshold and
//   binary_mode (latched at pixel (0,0)), pix_out/pix_valid/pix_ready with sof/eol/eof out,
//   overflow, frame_done.
module sobel_edge_post
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] edge_in,
    input  logic             edge_valid,
    input  logic [PIX_W-1:0] threshold,
    input  logic             binary_mode,
    output logic [PIX_W-1:0] pix_out,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic             overflow,
    output logic             frame_done
);

    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PIX_W-1:0] thr_lat;
    logic             mode_lat;

    logic             at_origin;
    logic             last_col;
    logic             last_row;
    logic             border;
    logic [PIX_W-1:0] eff_thr;
    logic             eff_mode;
    post_entry_t      new_entry;

    logic             stage_vld;
    post_entry_t      stage_dat;

    logic [POST_ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pop;
    post_entry_t             head;

    assign at_origin = (col == '0) && (row == '0);
    assign last_col  = (col == CW'(IMG_WIDTH - 1));
    assign last_row  = (row == RW'(IMG_HEIGHT - 1));
    assign border    = (row == '0) || last_row || (col == '0) || last_col;

    // The first pixel of a frame already uses the freshly presented settings.
    assign eff_thr  = at_origin ? threshold   : thr_lat;
    assign eff_mode = at_origin ? binary_mode : mode_lat;

    always_comb begin
        new_entry     = '0;
        new_entry.sof = at_origin;
        new_entry.eol = last_col;
        new_entry.eof = last_row && last_col;
        if (!border && (edge_in >= eff_thr)) begin
            new_entry.pix = eff_mode ? PIX_MAX : edge_in;
        end
    end

    // Raster counters advance on every valid input, dropped or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            thr_lat  <= '0;
            mode_lat <= 1'b0;
        end else if (edge_valid) begin
            if (at_origin) begin
                thr_lat  <= threshold;
                mode_lat <= binary_mode;
            end
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld <= 1'b0;
            stage_dat <= '0;
        end else begin
            stage_vld <= edge_valid;
            if (edge_valid) stage_dat <= new_entry;
        end
    end

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop        = pix_ready && !fifo_empty;

    sync_fifo #(
        .WIDTH (POST_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (stage_vld),
        .wr_data (stage_dat),
        .rd_en   (pix_ready),
        .rd_data (fifo_head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (stage_vld && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Pulses in the cycle the last pixel tries to enter the FIFO, drop or not.
    assign frame_done = stage_vld && stage_dat.eof;

    // Gate the head with valid so stale storage never shows on an empty FIFO.
    assign head      = fifo_empty ? '0 : post_entry_t'(fifo_head);
    assign pix_valid = !fifo_empty;
    assign pix_out   = head.pix;
    assign sof       = head.sof;
    assign eol       = head.eol;
    assign eof       = head.eof;

endmodule

// File: tb/tb_sobel_edge_post.sv
module tb_sobel_edge_post;
    import sobel_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] edge_in;
    logic       edge_valid;
    logic [7:0] threshold;
    logic       binary_mode;
    logic [7:0] pix_out;
    logic       pix_valid;
    logic       pix_ready;
    logic       sof, eol, eof, overflow, frame_done;

    always #5 clk = ~clk;

    sobel_edge_post #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .edge_in(edge_in), .edge_valid(edge_valid),
        .threshold(threshold), .binary_mode(binary_mode), .pix_out(pix_out),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .sof(sof), .eol(eol),
        .eof(eof), .overflow(overflow), .frame_done(frame_done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;

    // Reference model: raster position, frame settings, in-flight pixel, output queue.
    post_entry_t q[$];
    post_entry_t pend;
    bit          pend_vld;
    bit          m_ovf;
    int          m_col, m_row;
    int          m_thr;
    bit          m_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pend_vld = 0;
        pend     = '0;
        m_ovf    = 0;
        m_col    = 0;
        m_row    = 0;
        m_thr    = 0;
        m_mode   = 0;
    endtask

    function automatic post_entry_t model_pixel(input int din);
        post_entry_t e;
        bit interior;
        if (m_col == 0 && m_row == 0) begin
            m_thr  = threshold;
            m_mode = binary_mode;
        end
        interior = (m_row > 0) && (m_row < H - 1) && (m_col > 0) && (m_col < W - 1);
        e.sof = (m_row == 0) && (m_col == 0);
        e.eol = (m_col == W - 1);
        e.eof = (m_row == H - 1) && (m_col == W - 1);
        if (interior && din >= m_thr) e.pix = m_mode ? 8'd255 : 8'(din);
        else                          e.pix = 8'd0;
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row = (m_row + 1) % H;
        end
        return e;
    endfunction

    // One clock: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input bit ev, input int din, input bit rdy);
        bit full, pop;
        edge_valid = ev;
        edge_in    = 8'(din);
        pix_ready  = rdy;
        @(negedge clk);
        chk("pix_valid", pix_valid, (q.size() > 0));
        if (q.size() > 0) chk("head", {sof, eol, eof, pix_out}, q[0]);
        chk("overflow", overflow, m_ovf);
        chk("frame_done", frame_done, pend_vld && pend.eof);
        full = (q.size() == D);
        pop  = (q.size() > 0) && rdy;
        if (pop) begin
            void'(q.pop_front());
            n_out++;
        end
        if (pend_vld) begin
            if (full && !pop) m_ovf = 1;
            else              q.push_back(pend);
        end
        pend_vld = ev;
        if (ev) pend = model_pixel(din);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        edge_valid = 1'b0;
        #2;
        chk("rst_pix_out", pix_out, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_markers", {sof, eol, eof}, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_done", frame_done, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1);
    endtask

    int frame_b[16];
    int base;

    initial begin
        rst = 1'b0; edge_in = '0; edge_valid = 1'b0;
        threshold = '0; binary_mode = 1'b0; pix_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Magnitude mode, uniform frame.
        threshold = 8'd50; binary_mode = 1'b0;
        for (int i = 0; i < 16; i++) cycle(1, 100, 1);
        drain(4);
        chk("frame1_out_count", n_out, 16);

        // Binary mode, interior values around the threshold.
        binary_mode = 1'b1;
        for (int i = 0; i < 16; i++) frame_b[i] = 0;
        frame_b[5] = 49; frame_b[6] = 50; frame_b[9] = 51; frame_b[10] = 255;
        for (int i = 0; i < 16; i++) cycle(1, frame_b[i], 1);
        drain(4);

        // Mid-frame threshold change only takes effect at the next frame.
        binary_mode = 1'b0;
        threshold   = 8'd50;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) threshold = 8'd200;
            cycle(1, 100, 1);
        end
        for (int i = 0; i < 16; i++) cycle(1, 100, 1);
        drain(4);

        // Stalled sink: first four retained, rest dropped, overflow sticks.
        do_reset();
        threshold = 8'd50;
        base = n_out;
        for (int i = 0; i < 16; i++) cycle(1, 60 + i, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("bp_overflow", overflow, 1);
        chk("bp_valid", pix_valid, 1);
        drain(6);
        chk("bp_drained", n_out - base, 4);

        // Full FIFO with simultaneous push and pop never drops.
        do_reset();
        threshold = 8'd10;
        for (int i = 0; i < 4; i++) cycle(1, 20 + i, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(1, 30 + i, 1);
        drain(6);
        chk("fullrw_overflow", overflow, 0);

        // Reset in the middle of a frame restarts the raster.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1, 90, 1);
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, 90, 1);
        drain(4);

        // Random traffic, settings and sink behaviour.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) threshold = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) binary_mode = 1'($urandom_range(0, 1));
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 255),
                  ($urandom_range(0, 9) < 7));
        end
        drain(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_edge_post.md
# sobel_edge_post

Post-processing stage directly downstream of `sobel_top`. It consumes the `edge_out`/`edge_valid` magnitude stream and tracks the raster position of each pixel. It blanks the invalid one-pixel border and applies a per-frame threshold in binary or pass-through mode. Results are tagged with start-of-frame, end-of-line and end-of-frame markers and buffered in a small FIFO behind a ready/valid output, so the file-writer or display sink can stall without stalling the Sobel pipeline.

## Interface
- `IMG_WIDTH`, 256: pixels per line; must be ≥ 3.
- `IMG_HEIGHT`, 256: lines per frame; must be ≥ 3.
- `FIFO_DEPTH`, 4: output buffer entries; power of two, ≥ 2.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `edge_in` in 8: Sobel magnitude from `sobel_top.edge_out`.
- `edge_valid` in 1: `edge_in` is valid this cycle; there is no backpressure to upstream.
- `threshold` in 8: magnitude threshold, latched per frame.
- `binary_mode` in 1: 1 selects 0/255 output; 0 selects the magnitude or 0. Latched per frame.
- `pix_out` out 8: processed pixel.
- `pix_valid` out 1: FIFO head is valid.
- `pix_ready` in 1: the sink accepts the head when `pix_valid` and `pix_ready` are both high.
- `sof` out 1: head is pixel (0,0).
- `eol` out 1: head is the last column of a line.
- `eof` out 1: head is the last pixel of the frame.
- `overflow` out 1: sticky; a pixel was dropped because the FIFO was full.
- `frame_done` out 1: one-cycle pulse when the last input pixel of a frame is accepted.

## Operation
- **Position counters:**
  - `col` runs 0..IMG_WIDTH-1 and `row` runs 0..IMG_HEIGHT-1.
  - Both advance only on `edge_valid`.
  - `col` wraps to 0 and increments `row`. At (W-1,H-1) both wrap to 0.
  - Counters always advance, including when a pixel is dropped.
- **Per-frame latch:** `threshold` and `binary_mode` are captured on the `edge_valid` cycle where col=0 and row=0, and that pixel uses the new values. Mid-frame changes have no effect.
- **Classification:**
  - Border pixels (row 0, row H-1, col 0, col W-1) output 0.
  - Otherwise, the pixel passes when `edge_in` ≥ latched threshold. A passing pixel outputs 255 if binary mode is set, else `edge_in`. A failing pixel outputs 0.
  - The comparison is unsigned 8-bit. Threshold 0 passes every interior pixel.
- **Markers:**
  - `sof` = (row=0 && col=0).
  - `eol` = (col=W-1).
  - `eof` = (row=H-1 && col=W-1).
  - Markers are stored with the pixel in the FIFO as 11-bit entries: {sof, eol, eof, pix}.
- **FIFO:**
  - Show-ahead: the head is visible on the outputs while `pix_valid` is high.
  - A write and a read in the same cycle are both honoured at any occupancy, including full, where the pop frees the slot.
  - When the FIFO is full, no pop occurs and a stage entry is pending, the entry is discarded and `overflow` is set. `overflow` clears only on `rst`.
- **Reset:**
  - Asynchronous `rst`, asserted at any time including mid-frame, clears counters, the FIFO, the stage register and `overflow`.
  - Latched threshold and mode reset to 0.
  - Outputs reset to: `pix_out`=0, `pix_valid`=0, `sof`=0, `eol`=0, `eof`=0, `overflow`=0, `frame_done`=0.

## Timing
- **Stage 1:** a registered stage (valid bit plus entry) is loaded on the `edge_valid` cycle (cycle 0).
- **Stage 2:** on cycle 1 the entry is written to the FIFO, and `pix_valid` goes high in cycle 2 if the FIFO was empty. Minimum latency is 2 cycles.
- **Throughput:** one pixel per cycle sustained when `pix_ready` is held high.
- **`frame_done`:** high in cycle 1 of the last pixel (same cycle as its FIFO write attempt), independent of any drop.
- **Output stability:** while `pix_valid`=1 and `pix_ready`=0, `pix_out`, `sof`, `eol` and `eof` hold stable.
- **`overflow`:** rises in the cycle after the dropped write attempt.

## Structure
- **Shared package `sobel_pkg`:**
  - `PIX_W` = 8 and `PIX_MAX` = 8'hFF.
  - The post-FIFO entry type {sof, eol, eof, pix[7:0]}.
  - These are shared with `sobel_top` and the bench.
- **Sub-module `sync_fifo`:**
  - Parameterised width and depth, show-ahead, with an occupancy counter.
  - It is instantiated once with width 11. It is reusable for the future line-buffer bypass.
- **Top file:** holds the counters, the per-frame latch, the classifier and the stage register.

## Test plan
Benches use IMG_WIDTH=4, IMG_HEIGHT=4 and FIFO_DEPTH=4.
- **Interior threshold, magnitude mode:** stream 16 pixels of value 100 with `threshold`=50, `binary_mode`=0 and `pix_ready`=1.
  - Only (1,1), (2,1), (1,2) and (2,2) output 100; all others output 0.
  - `sof` is on output 0, `eol` on outputs 3, 7, 11 and 15, and `eof` on output 15.
  - `frame_done` pulses once.
- **Binary mode and boundary value:** interior values {49, 50, 51, 255} with `threshold`=50 and `binary_mode`=1 → outputs {0, 255, 255, 255}.
- **Per-frame latch:** change `threshold` from 50 to 200 at pixel 5 of frame 0.
  - Frame 0 still uses 50.
  - Frame 1, starting at (0,0), uses 200, so an interior 100 outputs 0.
- **Backpressure and overflow:** hold `pix_ready`=0 and stream 16 pixels.
  - `pix_valid` goes high after 2 cycles and the first 4 entries are retained.
  - `overflow`=1 from the 6th pixel onward.
  - Releasing `pix_ready` drains exactly 4 entries in order, with the markers intact.
- **Full simultaneous read/write:** fill the FIFO, then hold `pix_ready`=1 with continuous input.
  - No drop occurs and `overflow` stays 0.
  - Output order equals input order.
- **Mid-frame reset:** assert `rst` after pixel 6, then stream again.
  - All outputs read 0 during reset.
  - The next accepted pixel is tagged `sof`, with counters restarted at (0,0).
